// File: rtl/fm_ch_attr_kev.sv
// FM channel attribute store: per-channel attributes with power-up clear, registered CPU
// readback, range-checked access and latched key-on/key-off events with synth acknowledge.
module fm_ch_attr_kev #(
  parameter int unsigned NUM_CH = 32,
  parameter int unsigned FNUM_W = 10,
  localparam int unsigned AW    = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AW-1:0]     addr,
  input  logic [31:0]       wrdata,
  input  logic              wren,
  output logic [31:0]       rddata,
  output logic              busy,
  input  logic [AW-1:0]     ch_sel,
  input  logic              ch_evt_ack,
  output logic              ch_chb,
  output logic              ch_cha,
  output logic [2:0]        ch_fb,
  output logic              ch_cnt,
  output logic              ch_kon,
  output logic [2:0]        ch_block,
  output logic [FNUM_W-1:0] ch_fnum,
  output logic              ch_kon_evt,
  output logic              ch_koff_evt
);

  // RAM entry: {chb, cha, fb[2:0], cnt, block[2:0], fnum}; kon lives in a flop vector
  localparam int unsigned EW = 9 + FNUM_W;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t            state;
  logic [AW-1:0]     idx;
  logic [EW-1:0]     ram [NUM_CH];
  logic [NUM_CH-1:0] kon_q;
  logic [NUM_CH-1:0] kon_pend;
  logic [NUM_CH-1:0] koff_pend;
  logic [AW-1:0]     ch_sel_q;

  logic              addr_ok;
  logic              sel_ok;
  logic              sel_q_ok;
  logic              wr_run;
  logic              new_kon;
  logic              old_kon;
  logic              out_en;
  logic [EW-1:0]     wr_entry;
  logic [EW-1:0]     rd_entry;
  logic [EW-1:0]     sel_entry;
  logic [31:0]       rd_word;
  logic              unused_wrdata;

  // Index range checks collapse to constants when NUM_CH fills the index space
  if (NUM_CH == (1 << AW)) begin : g_full
    assign addr_ok  = 1'b1;
    assign sel_ok   = 1'b1;
    assign sel_q_ok = 1'b1;
  end else begin : g_part
    assign addr_ok  = (addr     < AW'(NUM_CH));
    assign sel_ok   = (ch_sel   < AW'(NUM_CH));
    assign sel_q_ok = (ch_sel_q < AW'(NUM_CH));
  end

  assign wr_entry      = {wrdata[21:16], wrdata[12:10], wrdata[FNUM_W-1:0]};
  assign new_kon       = wrdata[13];
  assign old_kon       = kon_q[addr];
  assign wr_run        = (state == S_RUN) && wren && addr_ok;
  assign unused_wrdata = ^wrdata;

  // Attribute RAM: single write port shared by the clear sweep and CPU writes
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      ram[idx] <= '0;
    end else if (wr_run) begin
      ram[addr] <= wr_entry;
    end
  end

  assign rd_entry = ram[addr];
  assign rd_word  = (32'(koff_pend[addr])            << 30) |
                    (32'(kon_pend[addr])             << 31) |
                    (32'(rd_entry[EW-1 -: 6])        << 16) |
                    (32'(kon_q[addr])                << 13) |
                    (32'(rd_entry[FNUM_W +: 3])      << 10) |
                    32'(rd_entry[FNUM_W-1:0]);

  // Control FSM, event flags and registered read path
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_CLEAR;
      idx       <= '0;
      busy      <= 1'b1;
      kon_q     <= '0;
      kon_pend  <= '0;
      koff_pend <= '0;
      ch_sel_q  <= '0;
      rddata    <= '0;
    end else begin
      ch_sel_q <= ch_sel;
      case (state)
        S_CLEAR: begin
          rddata <= '0;
          idx    <= idx + AW'(1);
          if (idx == AW'(NUM_CH - 1)) begin
            state <= S_RUN;
            busy  <= 1'b0;
          end
        end
        S_RUN: begin
          rddata <= addr_ok ? rd_word : '0;
          if (ch_evt_ack && sel_ok) begin
            kon_pend[ch_sel]  <= 1'b0;
            koff_pend[ch_sel] <= 1'b0;
          end
          // A write-generated event overrides a same-cycle acknowledge
          if (wr_run) begin
            kon_q[addr] <= new_kon;
            if (new_kon && !old_kon) begin
              kon_pend[addr]  <= 1'b1;
              koff_pend[addr] <= 1'b0;
            end else if (!new_kon && old_kon) begin
              koff_pend[addr] <= 1'b1;
              kon_pend[addr]  <= 1'b0;
            end
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  // Synth view of the registered channel select; zero while clearing or out of range
  assign out_en    = sel_q_ok && !busy;
  assign sel_entry = out_en ? ram[ch_sel_q] : '0;

  assign ch_chb      = sel_entry[EW-1];
  assign ch_cha      = sel_entry[EW-2];
  assign ch_fb       = sel_entry[EW-3 -: 3];
  assign ch_cnt      = sel_entry[FNUM_W+3];
  assign ch_block    = sel_entry[FNUM_W +: 3];
  assign ch_fnum     = sel_entry[FNUM_W-1:0];
  assign ch_kon      = out_en && kon_q[ch_sel_q];
  assign ch_kon_evt  = out_en && kon_pend[ch_sel_q];
  assign ch_koff_evt = out_en && koff_pend[ch_sel_q];

endmodule

// File: tb/tb_fm_ch_attr_kev.sv
// Bench for fm_ch_attr_kev: default instance checked against a word-level model under
// directed and random traffic; a 24-channel/12-bit instance covers range checks.
module tb_fm_ch_attr_kev;

  localparam logic [31:0] MASK10 = 32'h003F_3FFF & (32'h003F_3C00 | 32'h0000_03FF);

  logic        clk;
  logic        reset_n;

  logic [4:0]  d_addr;
  logic [31:0] d_wrdata;
  logic        d_wren;
  logic [31:0] d_rddata;
  logic        d_busy;
  logic [4:0]  d_sel;
  logic        d_ack;
  logic        d_chb, d_cha, d_cnt, d_kon, d_kon_evt, d_koff_evt;
  logic [2:0]  d_fb, d_block;
  logic [9:0]  d_fnum;

  logic [4:0]  e_addr;
  logic [31:0] e_wrdata;
  logic        e_wren;
  logic [31:0] e_rddata;
  logic        e_busy;
  logic [4:0]  e_sel;
  logic        e_ack;
  logic        e_chb, e_cha, e_cnt, e_kon, e_kon_evt, e_koff_evt;
  logic [2:0]  e_fb, e_block;
  logic [11:0] e_fnum;

  int n_cmp;
  int n_fail;

  logic [31:0] mw [32];
  logic [31:0] kp;
  logic [31:0] kf;

  fm_ch_attr_kev u_dut (
    .clk(clk), .reset_n(reset_n), .addr(d_addr), .wrdata(d_wrdata), .wren(d_wren),
    .rddata(d_rddata), .busy(d_busy), .ch_sel(d_sel), .ch_evt_ack(d_ack),
    .ch_chb(d_chb), .ch_cha(d_cha), .ch_fb(d_fb), .ch_cnt(d_cnt), .ch_kon(d_kon),
    .ch_block(d_block), .ch_fnum(d_fnum), .ch_kon_evt(d_kon_evt), .ch_koff_evt(d_koff_evt)
  );

  fm_ch_attr_kev #(.NUM_CH(24), .FNUM_W(12)) u_dut24 (
    .clk(clk), .reset_n(reset_n), .addr(e_addr), .wrdata(e_wrdata), .wren(e_wren),
    .rddata(e_rddata), .busy(e_busy), .ch_sel(e_sel), .ch_evt_ack(e_ack),
    .ch_chb(e_chb), .ch_cha(e_cha), .ch_fb(e_fb), .ch_cnt(e_cnt), .ch_kon(e_kon),
    .ch_block(e_block), .ch_fnum(e_fnum), .ch_kon_evt(e_kon_evt), .ch_koff_evt(e_koff_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] d_syn();
    return 32'({d_chb, d_cha, d_fb, d_cnt, d_kon, d_block, d_fnum, d_kon_evt, d_koff_evt});
  endfunction

  function automatic logic [31:0] e_syn();
    return 32'({e_chb, e_cha, e_fb, e_cnt, e_kon, e_block, e_fnum, e_kon_evt, e_koff_evt});
  endfunction

  // Expected synth outputs for a channel, taken from the stored word and pending flags
  function automatic logic [31:0] m_syn(input logic [4:0] s);
    logic [31:0] w;
    w = mw[s];
    return 32'({w[21], w[20], w[19:17], w[16], w[13], w[12:10], w[9:0], kp[s], kf[s]});
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mw[i] = '0;
    kp = '0;
    kf = '0;
  endtask

  // One clock of the default instance in RUN, with the model advanced for the same edge
  task automatic cyc(input logic wr, input logic [4:0] a, input logic [31:0] d,
                     input logic [4:0] s, input logic ack);
    logic [31:0] exp_rd;
    logic [31:0] nw;
    d_wren = wr; d_addr = a; d_wrdata = d; d_sel = s; d_ack = ack;
    exp_rd = mw[a] | (32'(kp[a]) << 31) | (32'(kf[a]) << 30);
    if (ack) begin
      kp[s] = 1'b0;
      kf[s] = 1'b0;
    end
    if (wr) begin
      nw = d & MASK10;
      if (!mw[a][13] && nw[13]) begin kp[a] = 1'b1; kf[a] = 1'b0; end
      if (mw[a][13] && !nw[13]) begin kf[a] = 1'b1; kp[a] = 1'b0; end
      mw[a] = nw;
    end
    @(posedge clk); #1;
    chk("rddata", d_rddata, exp_rd);
    chk("synth", d_syn(), m_syn(s));
  endtask

  task automatic ecyc(input logic wr, input logic [4:0] a, input logic [31:0] d,
                      input logic [4:0] s, input logic ack);
    e_wren = wr; e_addr = a; e_wrdata = d; e_sel = s; e_ack = ack;
    @(posedge clk); #1;
  endtask

  task automatic wait_clear(input int exp_d, input int exp_e);
    int d_done;
    int e_done;
    d_done = 0;
    e_done = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (k == 10) begin
        chk("clear_rd", d_rddata, 32'h0);
        chk("clear_syn", d_syn(), 32'h0);
      end
      if (!d_busy && d_done == 0) d_done = k;
      if (!e_busy && e_done == 0) e_done = k;
      if (d_done != 0 && e_done != 0) break;
    end
    chk("busy_cycles", 32'(d_done), 32'(exp_d));
    chk("busy_cycles24", 32'(e_done), 32'(exp_e));
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    model_clear();
    reset_n = 1'b0;
    d_wren = 1'b1; d_addr = 5'd5; d_wrdata = 32'hFFFF_FFFF; d_sel = 5'd5; d_ack = 1'b0;
    e_wren = 1'b1; e_addr = 5'd3; e_wrdata = 32'hFFFF_FFFF; e_sel = 5'd3; e_ack = 1'b0;

    // Reset state, then clear sequence with writes held active throughout
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(d_busy), 32'h1);
    chk("rst_rd", d_rddata, 32'h0);
    chk("rst_syn", d_syn(), 32'h0);
    chk("rst_syn24", e_syn(), 32'h0);
    reset_n = 1'b1;
    wait_clear(32, 24);

    e_wren = 1'b0;
    for (int i = 0; i < 32; i++) cyc(1'b0, 5'(i), 32'h0, 5'(i), 1'b0);

    // 24-channel instance: out-of-range access and 12-bit F-number round trip
    ecyc(1'b1, 5'd30, 32'hFFFF_FFFF, 5'd30, 1'b0);
    ecyc(1'b0, 5'd30, 32'h0, 5'd30, 1'b0);
    chk("oor_rd", e_rddata, 32'h0);
    chk("oor_syn", e_syn(), 32'h0);
    ecyc(1'b0, 5'd6, 32'h0, 5'd23, 1'b0);
    chk("oor_alias6", e_rddata, 32'h0);
    chk("oor_last_syn", e_syn(), 32'h0);
    ecyc(1'b1, 5'd3, 32'h0000_2ABC, 5'd3, 1'b0);
    ecyc(1'b0, 5'd3, 32'h0, 5'd3, 1'b0);
    chk("fnum12_rd", e_rddata, 32'h8000_2ABC);
    chk("fnum12_out", 32'(e_fnum), 32'hABC);
    chk("fnum12_blk", 32'(e_block), 32'h2);
    ecyc(1'b0, 5'd3, 32'h0, 5'd30, 1'b1);
    ecyc(1'b0, 5'd3, 32'h0, 5'd3, 1'b0);
    chk("oor_ack", 32'(e_kon_evt), 32'h1);
    chk("oor_ack_rd", e_rddata, 32'h8000_2ABC);

    // Key-on example, readback and acknowledge
    cyc(1'b1, 5'd5, 32'h0033_2A55, 5'd5, 1'b0);
    cyc(1'b0, 5'd5, 32'h0, 5'd5, 1'b0);
    chk("example_rd", d_rddata, 32'h8033_2A55);
    chk("example_syn", d_syn(),
        32'({1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 3'd2, 10'h255, 1'b1, 1'b0}));
    cyc(1'b0, 5'd5, 32'h0, 5'd5, 1'b1);
    chk("ack_kon", 32'(d_kon_evt), 32'h0);

    // Key-off, repeated kon=0 write, acknowledge
    cyc(1'b1, 5'd5, 32'h0033_0255, 5'd5, 1'b0);
    chk("koff_set", 32'({d_kon_evt, d_koff_evt}), 32'h1);
    cyc(1'b1, 5'd5, 32'h0033_0255, 5'd5, 1'b0);
    cyc(1'b0, 5'd5, 32'h0, 5'd5, 1'b1);
    chk("koff_ack", 32'({d_kon_evt, d_koff_evt}), 32'h0);
    cyc(1'b0, 5'd5, 32'h0, 5'd5, 1'b0);
    chk("koff_ack_rd", d_rddata, 32'h0033_0255);

    // Same-cycle write event and ack on one channel, then on different channels
    cyc(1'b1, 5'd7, 32'h0000_2123, 5'd7, 1'b1);
    chk("wr_beats_ack", 32'(d_kon_evt), 32'h1);
    cyc(1'b1, 5'd8, 32'h0000_2000, 5'd7, 1'b1);
    chk("ack_other", 32'(d_kon_evt), 32'h0);
    cyc(1'b0, 5'd8, 32'h0, 5'd8, 1'b0);
    chk("evt_other", 32'(d_kon_evt), 32'h1);

    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 1)), 5'($urandom), $urandom, 5'($urandom),
          1'($urandom_range(0, 9) < 3));
    end

    // Reset in the middle of RUN restarts the clear sequence
    d_wren = 1'b0; d_ack = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(d_busy), 32'h1);
    chk("midrst_rd", d_rddata, 32'h0);
    chk("midrst_syn", d_syn(), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_clear(32, 24);
    model_clear();
    for (int i = 0; i < 32; i++) cyc(1'b0, 5'(i), 32'h0, 5'(31 - i), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
